bmp_ram_streamer: RTL and testbench

//  Read-back side of the BMP frame RAM. Once a filter has written a full BMP image into RAM, this

---
 rtl/bmp_ram_streamer.sv | 186 ++++++++++++++++++
 tb/tb_bmp_ram_streamer.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bmp_ram_streamer.sv
// -----------------------------------------------------------------------------
// bmp_ram_streamer
//
// Purpose:
//   Reads a complete BMP file back out of the frame RAM byte by byte in address
//   order, checks the BMP header on the fly, captures width/height, and emits
//   the whole file as a valid/ready byte stream.
//
// Ports:
//   clk        - clock, all logic on posedge
//   rst        - synchronous active-high reset
//   start      - one-cycle pulse, begins a read-back from IDLE/DONE/ERR
//   RAM_valid  - RAM read enable
//   RAM_addr   - RAM read address (BASE_ADDR + byte index)
//   RAM_Q      - RAM read data, valid the cycle after RAM_valid
//   out_valid  - out_data holds a file byte
//   out_ready  - sink accepts the byte (transfer = out_valid & out_ready)
//   out_data   - file byte in address order
//   out_last   - marks file byte BMP_TOTAL_SIZE-1
//   width      - header bytes 18..21, little-endian
//   height     - header bytes 22..25, little-endian
//   busy       - high while streaming
//   done       - one-cycle pulse after the out_last transfer
//   hdr_err    - sticky header error, cleared by start or rst
// -----------------------------------------------------------------------------
module bmp_ram_streamer #(
  parameter int BYTE_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 20,
  parameter int BMP_TOTAL_SIZE = 786486,
  parameter int BASE_ADDR      = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  RAM_valid,
  output logic [ADDR_WIDTH-1:0] RAM_addr,
  input  logic [BYTE_WIDTH-1:0] RAM_Q,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [BYTE_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic [31:0]           width,
  output logic [31:0]           height,
  output logic                  busy,
  output logic                  done,
  output logic                  hdr_err
);

  localparam int CNT_W = $clog2(BMP_TOTAL_SIZE + 1);
  localparam logic [CNT_W-1:0] TOTAL    = CNT_W'(BMP_TOTAL_SIZE);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BMP_TOTAL_SIZE - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE, ERR} state_t;

  state_t                  state_reg;
  logic [CNT_W-1:0]        rd_cnt_reg;   // reads issued
  logic [CNT_W-1:0]        wr_cnt_reg;   // bytes pushed (index of next byte to push)
  logic                    q_pend_reg;   // a read was issued last cycle, RAM_Q valid now
  logic [1:0]              count_reg;    // FIFO occupancy
  logic                    rd_ptr_reg;
  logic                    wr_ptr_reg;
  logic [31:0]             width_reg;
  logic [31:0]             height_reg;
  logic                    done_reg;
  logic                    hdr_err_reg;

  logic [BYTE_WIDTH-1:0]   fifo_data [2];
  logic                    fifo_last [2];

  logic                    run;
  logic                    pop;
  logic [1:0]              occ_after_pop;
  logic                    issue;
  logic                    hdr_bad;
  logic                    push;
  logic                    last_push;

  assign run  = (state_reg == RUN);
  assign pop  = (count_reg != 2'd0) && out_ready;

  // Occupancy net of this cycle's pop. Counting the pop lets a read go out
  // every cycle in steady state, and still guarantees that the data from the
  // read issued now finds a free slot two edges later whatever out_ready does.
  assign occ_after_pop = count_reg - {1'b0, pop};
  assign issue = run && (rd_cnt_reg < TOTAL) &&
                 ((occ_after_pop + {1'b0, q_pend_reg}) < 2'd2);

  // Header bytes are checked as they arrive, before they enter the FIFO.
  always_comb begin
    hdr_bad = 1'b0;
    if (run && q_pend_reg) begin
      if (wr_cnt_reg == CNT_W'(0)  && RAM_Q != BYTE_WIDTH'(8'h42)) hdr_bad = 1'b1;
      if (wr_cnt_reg == CNT_W'(1)  && RAM_Q != BYTE_WIDTH'(8'h4D)) hdr_bad = 1'b1;
      if (wr_cnt_reg == CNT_W'(28) && RAM_Q != BYTE_WIDTH'(8'd24)) hdr_bad = 1'b1;
      if (wr_cnt_reg == CNT_W'(29) && RAM_Q != BYTE_WIDTH'(8'd0))  hdr_bad = 1'b1;
    end
  end

  assign push      = run && q_pend_reg && !hdr_bad;
  assign last_push = (wr_cnt_reg == LAST_IDX);

  // FIFO storage carries no reset; outputs are gated by occupancy instead.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr_reg] <= RAM_Q;
      fifo_last[wr_ptr_reg] <= last_push;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      rd_cnt_reg  <= '0;
      wr_cnt_reg  <= '0;
      q_pend_reg  <= 1'b0;
      count_reg   <= 2'd0;
      rd_ptr_reg  <= 1'b0;
      wr_ptr_reg  <= 1'b0;
      width_reg   <= '0;
      height_reg  <= '0;
      done_reg    <= 1'b0;
      hdr_err_reg <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE, DONE, ERR: begin
          if (start) begin
            state_reg   <= RUN;
            rd_cnt_reg  <= '0;
            wr_cnt_reg  <= '0;
            q_pend_reg  <= 1'b0;
            count_reg   <= 2'd0;
            rd_ptr_reg  <= 1'b0;
            wr_ptr_reg  <= 1'b0;
            width_reg   <= '0;
            height_reg  <= '0;
            hdr_err_reg <= 1'b0;
          end
        end
        RUN: begin
          if (hdr_bad) begin
            // Drop everything buffered or in flight; a byte popped this
            // same cycle has already been taken by the sink.
            state_reg   <= ERR;
            hdr_err_reg <= 1'b1;
            q_pend_reg  <= 1'b0;
            count_reg   <= 2'd0;
            rd_ptr_reg  <= 1'b0;
            wr_ptr_reg  <= 1'b0;
          end else begin
            q_pend_reg <= issue;
            if (issue) rd_cnt_reg <= rd_cnt_reg + CNT_W'(1);
            count_reg <= count_reg - {1'b0, pop} + {1'b0, push};
            if (pop) rd_ptr_reg <= ~rd_ptr_reg;
            if (push) begin
              wr_ptr_reg <= ~wr_ptr_reg;
              wr_cnt_reg <= wr_cnt_reg + CNT_W'(1);
              // Little-endian fields: shift new bytes in at the top.
              if (wr_cnt_reg >= CNT_W'(18) && wr_cnt_reg <= CNT_W'(21))
                width_reg <= {RAM_Q, width_reg[31:BYTE_WIDTH]};
              if (wr_cnt_reg >= CNT_W'(22) && wr_cnt_reg <= CNT_W'(25))
                height_reg <= {RAM_Q, height_reg[31:BYTE_WIDTH]};
            end
            if (pop && fifo_last[rd_ptr_reg]) begin
              state_reg <= DONE;
              done_reg  <= 1'b1;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign RAM_valid = issue;
  assign RAM_addr  = ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'(rd_cnt_reg);
  assign out_valid = (count_reg != 2'd0);
  assign out_data  = out_valid ? fifo_data[rd_ptr_reg] : '0;
  assign out_last  = out_valid && fifo_last[rd_ptr_reg];
  assign width     = width_reg;
  assign height    = height_reg;
  assign busy      = run;
  assign done      = done_reg;
  assign hdr_err   = hdr_err_reg;

endmodule

// File: tb/tb_bmp_ram_streamer.sv
// -----------------------------------------------------------------------------
// tb_bmp_ram_streamer
//
// Purpose:
//   Directed bench for bmp_ram_streamer using a small file (100 bytes) at a
//   non-zero base address. A behavioural RAM with one-cycle read latency
//   serves a bench-built image; a negedge monitor scores every read address
//   and every transferred byte against that image.
// -----------------------------------------------------------------------------
module tb_bmp_ram_streamer;

  localparam int BW   = 8;
  localparam int AW   = 20;
  localparam int N    = 100;
  localparam int BASE = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          RAM_valid;
  logic [AW-1:0] RAM_addr;
  logic [BW-1:0] RAM_Q;
  logic          out_valid;
  logic          out_ready;
  logic [BW-1:0] out_data;
  logic          out_last;
  logic [31:0]   width;
  logic [31:0]   height;
  logic          busy;
  logic          done;
  logic          hdr_err;

  bmp_ram_streamer #(
    .BYTE_WIDTH    (BW),
    .ADDR_WIDTH    (AW),
    .BMP_TOTAL_SIZE(N),
    .BASE_ADDR     (BASE)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .RAM_valid(RAM_valid),
    .RAM_addr (RAM_addr),
    .RAM_Q    (RAM_Q),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_last (out_last),
    .width    (width),
    .height   (height),
    .busy     (busy),
    .done     (done),
    .hdr_err  (hdr_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- RAM model ----------------
  logic [7:0] ram [0:N-1];
  logic [7:0] ram_q = 8'h00;
  assign RAM_Q = ram_q;

  always @(posedge clk) begin
    int idx;
    idx = int'(RAM_addr) - BASE;
    if (RAM_valid) ram_q <= (idx >= 0 && idx < N) ? ram[idx] : 8'hEE;
  end

  task automatic init_image(input int w, input int h);
    for (int i = 0; i < N; i++) ram[i] = 8'((i * 7 + 3) & 255);
    ram[0] = 8'h42; ram[1] = 8'h4D;
    ram[2] = 8'(N); ram[3] = 8'(N >> 8); ram[4] = 8'h00; ram[5] = 8'h00;
    ram[10] = 8'd54; ram[14] = 8'd40; ram[26] = 8'd1;
    ram[18] = 8'(w); ram[19] = 8'(w >> 8); ram[20] = 8'(w >> 16); ram[21] = 8'(w >> 24);
    ram[22] = 8'(h); ram[23] = 8'(h >> 8); ram[24] = 8'(h >> 16); ram[25] = 8'(h >> 24);
    ram[28] = 8'd24; ram[29] = 8'd0;
  endtask

  // ---------------- cycle counter and monitor ----------------
  int cyc = 0;
  int start_cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int rd_cnt, tx_cnt, done_cnt, done_rel, first_ram_rel, first_val_rel;
  logic          stall_prev = 1'b0;
  logic [BW-1:0] stall_data = '0;
  logic          stall_last = 1'b0;
  logic          rst_prev   = 1'b0;

  task automatic clr_mon();
    rd_cnt = 0; tx_cnt = 0; done_cnt = 0;
    done_rel = -1; first_ram_rel = -1; first_val_rel = -1;
  endtask

  always @(negedge clk) begin
    int rel;
    logic [31:0] exp_byte;
    rel = cyc - start_cyc + 1;
    if (stall_prev && !rst_prev && !hdr_err) begin
      check_eq("stall_valid", out_valid, 1);
      check_eq("stall_data", out_data, stall_data);
      check_eq("stall_last", out_last, stall_last);
    end
    if (RAM_valid) begin
      if (first_ram_rel < 0) first_ram_rel = rel;
      check_eq("ram_addr", RAM_addr, BASE + rd_cnt);
      check_eq("rd_range", rd_cnt < N, 1);
      rd_cnt++;
    end
    if (out_valid) begin
      if (first_val_rel < 0) first_val_rel = rel;
      check_eq("valid_busy", busy, 1);
    end
    if (out_valid && out_ready) begin
      exp_byte = (tx_cnt < N) ? 32'(ram[tx_cnt]) : 32'hFFFF;
      check_eq("out_data", out_data, exp_byte);
      check_eq("out_last", out_last, tx_cnt == N - 1);
      tx_cnt++;
    end
    if (RAM_valid || (out_valid && out_ready))
      check_eq("outstanding", (rd_cnt - tx_cnt) <= 2, 1);
    if (done) begin
      done_cnt++;
      done_rel = rel;
    end
    stall_prev = out_valid && !out_ready;
    stall_data = out_data;
    stall_last = out_last;
    rst_prev   = rst;
  end

  // ---------------- sink ready generator ----------------
  logic rand_ready = 1'b0;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) out_ready = ($urandom_range(0, 1) == 1);
    end
  end

  // ---------------- helpers ----------------
  task automatic pulse_start();
    clr_mon();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic wait_end(input int bound);
    int n;
    n = 0;
    while (!(done || hdr_err) && n < bound) begin
      @(negedge clk);
      n++;
    end
    check_eq("timeout", n < bound, 1);
  endtask

  task automatic report(input int id);
    $display("frame %0d: bytes=%0d done_pulses=%0d done_cycle=%0d hdr_err=%0b width=%0d height=%0d",
             id, tx_cnt, done_cnt, done_rel, hdr_err, width, height);
  endtask

  task automatic check_reset_state(input string pfx);
    check_eq({pfx, "_out_valid"}, out_valid, 0);
    check_eq({pfx, "_ram_valid"}, RAM_valid, 0);
    check_eq({pfx, "_ram_addr"}, RAM_addr, BASE);
    check_eq({pfx, "_out_data"}, out_data, 0);
    check_eq({pfx, "_out_last"}, out_last, 0);
    check_eq({pfx, "_busy"}, busy, 0);
    check_eq({pfx, "_done"}, done, 0);
    check_eq({pfx, "_hdr_err"}, hdr_err, 0);
    check_eq({pfx, "_width"}, width, 0);
    check_eq({pfx, "_height"}, height, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    int tx_hold;
    rst = 1'b1; start = 1'b0; out_ready = 1'b1;
    clr_mon();
    init_image(512, 512);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_state("reset");

    // Frame 1: full stream, sink always ready
    pulse_start();
    wait_end(400);
    repeat (3) @(negedge clk);
    check_eq("f1_first_ram", first_ram_rel, 1);
    check_eq("f1_first_valid", first_val_rel, 3);
    check_eq("f1_done_cycle", done_rel, N + 3);
    check_eq("f1_done_cnt", done_cnt, 1);
    check_eq("f1_bytes", tx_cnt, N);
    check_eq("f1_width", width, 32'd512);
    check_eq("f1_height", height, 32'd512);
    check_eq("f1_busy", busy, 0);
    check_eq("f1_out_valid", out_valid, 0);
    check_eq("f1_hdr_err", hdr_err, 0);
    report(1);

    // Frame 2: random backpressure
    rand_ready = 1'b1;
    pulse_start();
    wait_end(2000);
    rand_ready = 1'b0;
    @(negedge clk);
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("f2_done_cnt", done_cnt, 1);
    check_eq("f2_bytes", tx_cnt, N);
    check_eq("f2_width", width, 32'd512);
    check_eq("f2_height", height, 32'd512);
    report(2);

    // Frame 3a: bad signature byte 0
    ram[0] = 8'h00;
    pulse_start();
    repeat (20) @(negedge clk);
    check_eq("f3a_bytes", tx_cnt, 0);
    check_eq("f3a_hdr_err", hdr_err, 1);
    check_eq("f3a_ram_valid", RAM_valid, 0);
    check_eq("f3a_done_cnt", done_cnt, 0);
    check_eq("f3a_busy", busy, 0);
    check_eq("f3a_out_valid", out_valid, 0);
    report(3);

    // Frame 3b: bad bit depth at byte 28
    ram[0] = 8'h42;
    ram[28] = 8'd8;
    pulse_start();
    @(negedge clk);
    check_eq("f3b_err_cleared", hdr_err, 0);
    wait_end(400);
    repeat (10) @(negedge clk);
    check_eq("f3b_bytes", tx_cnt, 28);
    check_eq("f3b_hdr_err", hdr_err, 1);
    check_eq("f3b_busy", busy, 0);
    check_eq("f3b_done_cnt", done_cnt, 0);
    check_eq("f3b_ram_valid", RAM_valid, 0);
    report(4);

    // Frame 4: reset in mid-frame, then a clean restart
    ram[28] = 8'd24;
    pulse_start();
    n = 0;
    while (tx_cnt < 40 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check_eq("f4_reach40", n < 500, 1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_reset_state("midrst");
    tx_hold = tx_cnt;
    repeat (10) @(negedge clk);
    check_eq("f4_no_bytes_after_rst", tx_cnt, tx_hold);
    pulse_start();
    wait_end(400);
    repeat (3) @(negedge clk);
    check_eq("f4_first_ram", first_ram_rel, 1);
    check_eq("f4_bytes", tx_cnt, N);
    check_eq("f4_done_cnt", done_cnt, 1);
    report(5);

    // Frame 5: start during RUN is ignored
    pulse_start();
    repeat (10) @(negedge clk);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    check_eq("f5_still_busy", busy, 1);
    wait_end(400);
    repeat (3) @(negedge clk);
    check_eq("f5_bytes", tx_cnt, N);
    check_eq("f5_done_cnt", done_cnt, 1);
    check_eq("f5_done_cycle", done_rel, N + 3);
    report(6);

    // Frame 6: restart from DONE with new dimensions
    init_image(320, 240);
    pulse_start();
    wait_end(400);
    repeat (3) @(negedge clk);
    check_eq("f6_bytes", tx_cnt, N);
    check_eq("f6_done_cnt", done_cnt, 1);
    check_eq("f6_width", width, 32'd320);
    check_eq("f6_height", height, 32'd240);
    report(7);

    // start and rst together: reset wins
    tx_hold = tx_cnt;
    @(posedge clk); #1 begin rst = 1'b1; start = 1'b1; end
    @(posedge clk); #1 begin rst = 1'b0; start = 1'b0; end
    @(negedge clk);
    check_reset_state("rst_start");
    repeat (5) @(negedge clk);
    check_eq("rst_start_idle", busy, 0);
    check_eq("rst_start_no_bytes", tx_cnt, tx_hold);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
